lsu_bus: RTL
============

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the data/address width; legal values are 32 and 64.
REQ-002 The block SHALL have the following ports, with NB = XLEN/8:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low.
- ReqValid  in  1  the core presents a memory operation.
- ReqWrite  in  1  1 = store, 0 = load.
- Funct3  in  3  RISC-V size/sign code.
- Adr  in  XLEN  byte address.
- WriteData  in  XLEN  store data, right-aligned.
- Stall  out  1  the core holds its request and PC.
- LoadResult  out  XLEN  sign- or zero-extended load data.
- LoadValid  out  1  one-cycle pulse when the access completes.
- Fault  out  1  one-cycle pulse on an illegal or misaligned access.
- BusValid  out  1  bus request.
- BusWrite  out  1  bus write.
- BusAdr  out  XLEN  NB-aligned bus address.
- BusByteEn  out  NB  bus byte lanes.
- BusWData  out  XLEN  lane-aligned store data.
- BusReady  in  1  handshake completes when BusValid and BusReady are both 1.
- BusRData  in  XLEN  read data, valid in the handshake cycle.

Function
REQ-003 The FSM SHALL have four states: IDLE, ACC0, ACC1, RESP.
REQ-004 In IDLE with ReqValid=1 and a legal access, the block SHALL latch Adr, Funct3, ReqWrite and WriteData, and go to ACC0.
REQ-005 Legal Funct3 values SHALL be:
- loads: 000, 001, 010, 100, 101; additionally 011 and 110 when XLEN=64.
- stores: 000, 001, 010; additionally 011 when XLEN=64.
- any other code is illegal.
REQ-006 An illegal Funct3 SHALL pulse Fault for one cycle, issue no bus access, and leave the FSM in IDLE.
REQ-007 Stall SHALL be asserted in ACC0 and ACC1, and combinationally in IDLE when ReqValid=1 and no Fault is raised; Stall SHALL be 0 in RESP.
REQ-008 BusValid SHALL be 1 exactly in ACC0 and ACC1.
- BusAdr, BusWrite, BusByteEn and BusWData SHALL be registered and stable until the handshake.
- BusValid SHALL NOT drop before BusReady is seen.
REQ-009 Beat 0 SHALL use BusAdr = Adr with the low log2(NB) bits cleared.
- Byte enables cover access bytes from offset Adr mod NB up to lane NB-1.
- Store data is shifted left by 8*offset bits.
REQ-010 On the ACC0 handshake, the FSM SHALL go to ACC1 if the access crosses an NB boundary, otherwise to RESP.
REQ-011 Beat 1 SHALL use BusAdr = beat-0 address + NB, with the remaining low-lane byte enables and the remaining store bytes.
REQ-012 Read bytes SHALL be captured from each beat's handshake cycle and merged in byte order.
REQ-013 In RESP the block SHALL pulse LoadValid and drive LoadResult, then go to IDLE on the next edge.
- LoadResult is sign-extended for codes 000/001/010 and zero-extended for 100/101/110; 011 is a full XLEN load.
- For stores, LoadResult SHALL be 0 and LoadValid SHALL still pulse.
REQ-014 In RESP, ReqValid SHALL be ignored; the held request is not relaunched.
REQ-015 Minimum latency from ReqValid to LoadValid SHALL be 2 cycles for a single beat and 3 for a split access, plus one cycle for each BusReady=0 wait state.
REQ-016 LoadResult SHALL hold its value until the next RESP.

Reset
REQ-017 When reset=0, the block SHALL immediately enter IDLE and drive to 0: BusValid, BusWrite, BusAdr, BusByteEn, BusWData, Stall, LoadValid, Fault and LoadResult.
REQ-018 Reset during ACC0 or ACC1 SHALL abandon the access; no partial result is delivered after reset is released.

Configuration
REQ-019 The macro LSU_BUS_MISALIGN_EN SHALL control handling of misaligned accesses.
- Defined: boundary-crossing accesses are split into two beats per REQ-010 and REQ-011.
- Undefined: any access whose size does not divide Adr SHALL pulse Fault, with no bus access and the FSM staying in IDLE; ACC1 is never entered.

Verification
REQ-020 XLEN=32, LW at Adr=0x100, BusReady=1 throughout, BusRData=0xDEADBEEF -> BusAdr=0x100, BusByteEn=1111, LoadValid 2 cycles after ReqValid, LoadResult=0xDEADBEEF.
REQ-021 LB at Adr=0x103 with BusRData=0x80000000 -> BusByteEn=1000, LoadResult=0xFFFFFF80; LBU at the same address -> LoadResult=0x00000080.
REQ-022 SH at Adr=0x203 with WriteData=0xABCD, macro defined:
- beat 0: BusAdr=0x200, BusByteEn=1000, BusWData[31:24]=0xCD.
- beat 1: BusAdr=0x204, BusByteEn=0001, BusWData[7:0]=0xAB.
- LoadValid pulses 3 cycles after ReqValid.
- With the macro undefined: Fault pulse, BusValid stays 0.
REQ-023 LW with BusReady held 0 for 3 cycles -> BusValid and BusAdr stable for 4 cycles, Stall=1 throughout, LoadValid one cycle after the handshake.
REQ-024 Reset asserted in ACC1 of a split load -> BusValid=0 and Stall=0 immediately; after release, no LoadValid pulse.
REQ-025 XLEN=64, LD at Adr=0x1000 with BusRData=0x0123456789ABCDEF -> BusByteEn=0xFF, LoadResult=0x0123456789ABCDEF; Funct3=111 load -> Fault pulse, no bus access.

Source files
------------

// File: rtl/lsu_bus_if.sv
// Core-request and memory-bus signal bundle for lsu_bus.
// master: the load/store unit itself; slave: the core plus memory side.
interface lsu_bus_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    logic            ReqValid;
    logic            ReqWrite;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] Adr;
    logic [XLEN-1:0] WriteData;
    logic            Stall;
    logic [XLEN-1:0] LoadResult;
    logic            LoadValid;
    logic            Fault;
    logic            BusValid;
    logic            BusWrite;
    logic [XLEN-1:0] BusAdr;
    logic [NB-1:0]   BusByteEn;
    logic [XLEN-1:0] BusWData;
    logic            BusReady;
    logic [XLEN-1:0] BusRData;

    modport master (
        input  ReqValid, ReqWrite, Funct3, Adr, WriteData, BusReady, BusRData,
        output Stall, LoadResult, LoadValid, Fault,
        output BusValid, BusWrite, BusAdr, BusByteEn, BusWData
    );

    modport slave (
        output ReqValid, ReqWrite, Funct3, Adr, WriteData, BusReady, BusRData,
        input  Stall, LoadResult, LoadValid, Fault,
        input  BusValid, BusWrite, BusAdr, BusByteEn, BusWData
    );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit: turns one core memory request into one or two aligned bus beats.
// Define LSU_BUS_MISALIGN_EN to split boundary-crossing accesses; otherwise they fault.
module lsu_bus #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       reset,
    lsu_bus_if.master bus
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [OW-1:0]     off_q, off_d;
    logic              write_q, write_d;
    logic              cross_q, cross_d;
    logic [NB-1:0]     be1_q, be1_d;
    logic [XLEN-1:0]   wd1_q, wd1_d;
    logic [XLEN-1:0]   rbuf_q, rbuf_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              bus_write_q, bus_write_d;
    logic [XLEN-1:0]   bus_adr_q, bus_adr_d;
    logic [NB-1:0]     bus_be_q, bus_be_d;
    logic [XLEN-1:0]   bus_wdata_q, bus_wdata_d;

    logic              stall, fault, load_valid, bus_valid;
    logic              req_legal, req_misalign, req_cross;
    logic [OW-1:0]     req_off;
    logic [2*NB-1:0]   req_lanes;
    logic [2*XLEN-1:0] req_data;
    logic [2*XLEN-1:0] merged;
    logic [XLEN-1:0]   aligned;

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        logic [XLEN-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NB; i++)
            if (i < (32'd1 << sz)) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic is_legal(input logic wr, input logic [2:0] f3);
        if (wr) return (f3[2] == 1'b0) && ((f3[1:0] != 2'b11) || (XLEN == 64));
        return (f3 != 3'b111) && (((f3 != 3'b011) && (f3 != 3'b110)) || (XLEN == 64));
    endfunction

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        logic            sgn;
        int unsigned     nbits;
        nbits = 32'd8 << f3[1:0];
        if (nbits > XLEN) nbits = XLEN;
        sgn = !f3[2] && d[nbits-1];
        for (int unsigned i = 0; i < XLEN; i++) r[i] = (i < nbits) ? d[i] : sgn;
        return r;
    endfunction

    always_comb begin
        req_off   = bus.Adr[OW-1:0];
        req_lanes = '0;
        for (int unsigned i = 0; i < NB; i++)
            req_lanes[i] = (i < (32'd1 << bus.Funct3[1:0]));
        req_lanes = req_lanes << req_off;
        req_data  = {{XLEN{1'b0}}, bus.WriteData & size_mask(bus.Funct3[1:0])} << {req_off, 3'b000};
        req_legal = is_legal(bus.ReqWrite, bus.Funct3);
`ifdef LSU_BUS_MISALIGN_EN
        req_misalign = 1'b0;
        req_cross    = |req_lanes[2*NB-1:NB];
`else
        req_misalign = |(req_off & OW'((32'd1 << bus.Funct3[1:0]) - 32'd1));
        req_cross    = 1'b0;
`endif
        // Beat-0 bytes sit in rbuf_q; beat 1 supplies the upper half of the window.
        merged  = (state_q == ACC1) ? {bus.BusRData, rbuf_q} : {{XLEN{1'b0}}, bus.BusRData};
        aligned = XLEN'(merged >> {off_q, 3'b000});
    end

    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        off_d       = off_q;
        write_d     = write_q;
        cross_d     = cross_q;
        be1_d       = be1_q;
        wd1_d       = wd1_q;
        rbuf_d      = rbuf_q;
        result_d    = result_q;
        bus_write_d = bus_write_q;
        bus_adr_d   = bus_adr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        stall       = 1'b0;
        fault       = 1'b0;
        load_valid  = 1'b0;
        bus_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                // reset gating keeps the combinational outputs quiet while held in reset
                if (bus.ReqValid && reset) begin
                    if (!req_legal || req_misalign) begin
                        fault = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        f3_d        = bus.Funct3;
                        off_d       = req_off;
                        write_d     = bus.ReqWrite;
                        cross_d     = req_cross;
                        be1_d       = req_lanes[2*NB-1:NB];
                        wd1_d       = req_data[2*XLEN-1:XLEN];
                        bus_write_d = bus.ReqWrite;
                        bus_adr_d   = {bus.Adr[XLEN-1:OW], {OW{1'b0}}};
                        bus_be_d    = req_lanes[NB-1:0];
                        bus_wdata_d = req_data[XLEN-1:0];
                        state_d     = ACC0;
                    end
                end
            end
            ACC0: begin
                stall     = 1'b1;
                bus_valid = 1'b1;
                if (bus.BusReady) begin
                    if (cross_q) begin
                        rbuf_d      = bus.BusRData;
                        bus_adr_d   = bus_adr_q + XLEN'(NB);
                        bus_be_d    = be1_q;
                        bus_wdata_d = wd1_q;
                        state_d     = ACC1;
                    end else begin
                        result_d = write_q ? '0 : extend(aligned, f3_q);
                        state_d  = RESP;
                    end
                end
            end
            ACC1: begin
                stall     = 1'b1;
                bus_valid = 1'b1;
                if (bus.BusReady) begin
                    result_d = write_q ? '0 : extend(aligned, f3_q);
                    state_d  = RESP;
                end
            end
            RESP: begin
                load_valid = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            f3_q        <= '0;
            off_q       <= '0;
            write_q     <= 1'b0;
            cross_q     <= 1'b0;
            be1_q       <= '0;
            wd1_q       <= '0;
            rbuf_q      <= '0;
            result_q    <= '0;
            bus_write_q <= 1'b0;
            bus_adr_q   <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            write_q     <= write_d;
            cross_q     <= cross_d;
            be1_q       <= be1_d;
            wd1_q       <= wd1_d;
            rbuf_q      <= rbuf_d;
            result_q    <= result_d;
            bus_write_q <= bus_write_d;
            bus_adr_q   <= bus_adr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus.Stall      = stall;
    assign bus.Fault      = fault;
    assign bus.LoadValid  = load_valid;
    assign bus.LoadResult = result_q;
    assign bus.BusValid   = bus_valid;
    assign bus.BusWrite   = bus_write_q;
    assign bus.BusAdr     = bus_adr_q;
    assign bus.BusByteEn  = bus_be_q;
    assign bus.BusWData   = bus_wdata_q;
endmodule
